sht_frame_checker: RTL and testbench
====================================

Name: sht_frame_checker

Overview:
- Parametrised successor to the SHT40 receive/CRC block.
- Accepts the byte stream from the I2C master over a valid/ready handshake.
- Groups bytes into N_WORDS words, each made of data bytes followed by one CRC-8 byte, and checks each CRC bitwise over 8 cycles per data byte.
- Emits each checked word with an index, plus per-frame completion and error status, to downstream sensor logic.

Parameters:
- N_WORDS, 2, words per frame (SHT40: temperature, humidity); range 1..8
- DATA_BYTES, 2, data bytes per word before its CRC byte; range 1..4
- CRC_POLY, 8'h31, CRC-8 polynomial, MSB-first, x^8 implicit
- CRC_INIT, 8'hFF, CRC register value at the start of each word
- ABORT_ON_ERR, 1, 1: a CRC mismatch ends the frame; 0: continue with the remaining words

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; arms a new frame and aborts any frame in progress
- byte_in  in  8  received byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  block can accept a byte this cycle
- word_out  out  8*DATA_BYTES  checked word, first received byte in the MSBs
- word_idx  out  3  index of word_out, 0..N_WORDS-1
- word_valid  out  1  one-cycle pulse; word_out passed its CRC
- crc_err  out  1  one-cycle pulse; word_out failed its CRC
- frame_done  out  1  one-cycle pulse; frame finished (all words, or abort)
- frame_err  out  1  sticky; any CRC error in the current frame; cleared by frame_start
- err_count  out  8  saturating count of CRC errors since reset

Behaviour:
- Reset values: every output is 0, including byte_ready, word_out and err_count. State is IDLE, crc = CRC_INIT, all indices 0.
- Handshake: a byte is accepted only in a cycle where byte_valid && byte_ready.
- State IDLE:
  - byte_ready = 0.
  - frame_start moves to ACCEPT with word_idx = 0, byte index = 0, crc = CRC_INIT, frame_err = 0.
- State ACCEPT (byte_ready = 1):
  - Data byte accepted (byte index < DATA_BYTES):
    - crc <= crc ^ byte_in.
    - The byte is shifted into the word register.
    - Go to SHIFT with bit counter = 0.
  - CRC byte accepted (byte index == DATA_BYTES): compare byte_in with crc, then go to REPORT.
- State SHIFT (byte_ready = 0), for exactly 8 cycles:
  - If crc[7] is 1: crc <= {crc[6:0], 0} ^ CRC_POLY.
  - Otherwise: crc <= {crc[6:0], 0}.
  - After the 8th shift, increment the byte index and return to ACCEPT.
  - Timing: a data byte accepted in cycle T gives byte_ready = 0 in T+1..T+8 and byte_ready = 1 in T+9.
- State REPORT, one cycle, asserted in cycle T+1 after a CRC byte accepted in cycle T:
  - Pulse word_valid (match) or crc_err (mismatch).
  - word_out and word_idx are stable in this cycle and hold until the next REPORT.
  - On mismatch: set frame_err and increment err_count, saturating at 8'hFF.
- REPORT transitions:
  - Last word (word_idx == N_WORDS-1): pulse frame_done in the same cycle, go to IDLE.
  - Mismatch with ABORT_ON_ERR = 1: pulse frame_done, go to IDLE; the rest of the frame is not accepted.
  - Otherwise: word_idx++, byte index = 0, crc = CRC_INIT, go to ACCEPT.
- frame_start in any non-IDLE state:
  - Drops the partial word and re-arms as from IDLE; no pulse for the dropped word.
  - Takes priority over a byte_valid in the same cycle; that byte is not accepted.
- rst has priority over everything and acts in any state, including mid-SHIFT.
- byte_valid outside ACCEPT is ignored; the upstream source must hold the byte until byte_ready is high.

Decomposition:
- Shared package sht_pkg holds:
  - the state enum (IDLE, ACCEPT, SHIFT, REPORT);
  - SHT_CRC_POLY = 8'h31 and SHT_CRC_INIT = 8'hFF;
  - SHT40 frame constants: N_WORDS = 2, DATA_BYTES = 2.
- One sub-module, crc8_serial: load/xor input, 8-cycle shift engine, done flag, POLY parameter. It is reusable for the future write-side CRC.

Test Plan:
- Default parameters; frame_start, then bytes BE EF 92 66 66 93:
  - word_valid at word_idx 0 with word_out 16'hBEEF;
  - word_valid at word_idx 1 with word_out 16'h6666, and frame_done in that same cycle;
  - frame_err = 0, err_count = 0.
- Bytes 00 00 81 then 00 00 00, ABORT_ON_ERR = 1:
  - word 0 is valid;
  - word 1 gives a crc_err pulse with frame_done, frame_err = 1, err_count = 1.
- Bytes BE EF 00 then 66 66 93, ABORT_ON_ERR = 0:
  - word 0 gives crc_err;
  - word 1 gives word_valid, plus frame_done; frame_err stays 1.
- frame_start pulsed 3 cycles into SHIFT after BE, then BE EF 92 66 66 93:
  - no pulse for the aborted partial word;
  - the new frame completes cleanly at word_idx 0 and 1.
- byte_valid held high continuously:
  - byte_ready is low for exactly 8 cycles after each data byte;
  - no byte is accepted twice or lost.
- rst asserted during SHIFT: all outputs 0 on the next cycle and the state is IDLE.
- 256 bad-CRC words: err_count saturates at 8'hFF.

Source files
------------

// File: rtl/sht_pkg.sv
// Shared types and SHT40 constants for the sensor receive path.
// Also holds the single-bit CRC-8 step so the read and write paths agree on it.
package sht_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [7:0] SHT_CRC_POLY   = 8'h31;
  localparam logic [7:0] SHT_CRC_INIT   = 8'hFF;
  localparam int         SHT_N_WORDS    = 2;
  localparam int         SHT_DATA_BYTES = 2;

  // One MSB-first shift of the CRC register, x^8 implicit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] poly);
    return crc[7] ? ({crc[6:0], 1'b0} ^ poly) : {crc[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine: load xors a byte in, then eight shift cycles follow.
// done is high during the eighth shift; init cancels any shift in progress.
module crc8_serial
  import sht_pkg::*;
#(
  parameter logic [7:0] POLY = SHT_CRC_POLY,
  parameter logic [7:0] INIT = SHT_CRC_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] crc,
  output logic       done
);

  logic       busy;
  logic [2:0] bit_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc     <= INIT;
      busy    <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (init) begin
      crc     <= INIT;
      busy    <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (load) begin
      crc     <= crc ^ din;
      busy    <= 1'b1;
      bit_cnt <= 3'd0;
    end else if (busy) begin
      crc     <= crc8_step(crc, POLY);
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) busy <= 1'b0;
    end
  end

  assign done = busy && (bit_cnt == 3'd7);

endmodule

// File: rtl/sht_frame_checker.sv
// Receive-side frame checker: groups bytes into words, checks each word's
// CRC-8 serially and reports per-word and per-frame status downstream.
module sht_frame_checker
  import sht_pkg::*;
#(
  parameter int         N_WORDS      = SHT_N_WORDS,
  parameter int         DATA_BYTES   = SHT_DATA_BYTES,
  parameter logic [7:0] CRC_POLY     = SHT_CRC_POLY,
  parameter logic [7:0] CRC_INIT     = SHT_CRC_INIT,
  parameter bit         ABORT_ON_ERR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [8*DATA_BYTES-1:0] word_out,
  output logic [2:0]              word_idx,
  output logic                    word_valid,
  output logic                    crc_err,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [7:0]              err_count
);

  localparam int         W         = 8 * DATA_BYTES;
  localparam logic [2:0] CRC_SLOT  = 3'(DATA_BYTES);
  localparam logic [2:0] LAST_WORD = 3'(N_WORDS - 1);

  state_t         state, next_state;
  logic [2:0]     byte_idx, widx;
  logic [W-1:0]   word_reg;
  logic           match;
  logic [7:0]     crc;
  logic           crc_done;
  logic           accept, data_acc, crc_acc;

  // frame_start wins over a byte offered in the same cycle.
  assign accept   = (state == ACCEPT) && byte_valid && !frame_start;
  assign data_acc = accept && (byte_idx != CRC_SLOT);
  assign crc_acc  = accept && (byte_idx == CRC_SLOT);

  crc8_serial #(.POLY(CRC_POLY), .INIT(CRC_INIT)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (frame_start || (state == REPORT)),
    .load (data_acc),
    .din  (byte_in),
    .crc  (crc),
    .done (crc_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    byte_ready = (state == ACCEPT);
    word_valid = (state == REPORT) && match;
    crc_err    = (state == REPORT) && !match;
    frame_done = (state == REPORT) && ((widx == LAST_WORD) || (!match && ABORT_ON_ERR));
    unique case (state)
      IDLE:    next_state = IDLE;
      ACCEPT:  if (data_acc) next_state = SHIFT;
               else if (crc_acc) next_state = REPORT;
      SHIFT:   if (crc_done) next_state = ACCEPT;
      REPORT:  next_state = frame_done ? IDLE : ACCEPT;
      default: next_state = IDLE;
    endcase
    if (frame_start) next_state = ACCEPT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx  <= 3'd0;
      widx      <= 3'd0;
      word_reg  <= '0;
      word_out  <= '0;
      word_idx  <= 3'd0;
      match     <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else if (frame_start) begin
      byte_idx  <= 3'd0;
      widx      <= 3'd0;
      frame_err <= 1'b0;
    end else begin
      if (data_acc) word_reg <= (word_reg << 8) | W'(byte_in);
      if (crc_done) byte_idx <= byte_idx + 3'd1;
      // Error status lands with the compare so it is visible in the REPORT cycle.
      if (crc_acc) begin
        match    <= (byte_in == crc);
        word_out <= word_reg;
        word_idx <= widx;
        if (byte_in != crc) begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
      if ((state == REPORT) && !frame_done) begin
        widx     <= widx + 3'd1;
        byte_idx <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_sht_frame_checker.sv
// Directed scoreboard bench: A aborts on CRC error (default), B continues.
// Expected word reports are queued as stimulus is driven and popped by monitors.
module tb_sht_frame_checker;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] word;
    logic        err;
    logic        done;
    logic        ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, frame_start, byte_valid;
  logic [7:0] byte_in;
  logic       en_a, en_b, sel;

  logic        ready_a, wv_a, ce_a, fd_a, fe_a;
  logic [15:0] wo_a;
  logic [2:0]  idx_a;
  logic [7:0]  ec_a;
  logic        ready_b, wv_b, ce_b, fd_b, fe_b;
  logic [15:0] wo_b;
  logic [2:0]  idx_b;
  logic [7:0]  ec_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_err_a = 0;
  int   lows, highs;

  always #5 clk = ~clk;

  sht_frame_checker dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start & en_a), .byte_in(byte_in),
    .byte_valid(byte_valid & en_a), .byte_ready(ready_a), .word_out(wo_a),
    .word_idx(idx_a), .word_valid(wv_a), .crc_err(ce_a), .frame_done(fd_a),
    .frame_err(fe_a), .err_count(ec_a)
  );

  sht_frame_checker #(.ABORT_ON_ERR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start & en_b), .byte_in(byte_in),
    .byte_valid(byte_valid & en_b), .byte_ready(ready_b), .word_out(wo_b),
    .word_idx(idx_b), .word_valid(wv_b), .crc_err(ce_b), .frame_done(fd_b),
    .frame_err(fe_b), .err_count(ec_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] idx, input logic [15:0] word,
                              input logic err, input logic done, input logic ferr);
    exp_t e;
    e.idx = idx; e.word = word; e.err = err; e.done = done; e.ferr = ferr;
    return e;
  endfunction

  task automatic check_evt(input string who, input exp_t e, input logic wv, input logic ce,
                           input logic fd, input logic [2:0] idx, input logic [15:0] wo,
                           input logic fe);
    check({who, "_word_idx"},   idx, e.idx);
    check({who, "_word_out"},   wo,  e.word);
    check({who, "_word_valid"}, wv,  !e.err);
    check({who, "_crc_err"},    ce,  e.err);
    check({who, "_frame_done"}, fd,  e.done);
    check({who, "_frame_err"},  fe,  e.ferr);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wv_a || ce_a || fd_a) begin
      if (q_a.size() == 0) check("A_unexpected_report", 1, 0);
      else begin
        e = q_a.pop_front();
        check_evt("A", e, wv_a, ce_a, fd_a, idx_a, wo_a, fe_a);
      end
    end
    if (wv_b || ce_b || fd_b) begin
      if (q_b.size() == 0) check("B_unexpected_report", 1, 0);
      else begin
        e = q_b.pop_front();
        check_evt("B", e, wv_b, ce_b, fd_b, idx_b, wo_b, fe_b);
      end
    end
  end

  function automatic logic rdy();
    return sel ? ready_b : ready_a;
  endfunction

  // Offers a byte (valid stays high afterwards) and returns how many cycles
  // byte_ready was low before acceptance. Entered and left #1 after a posedge.
  task automatic send(input logic [7:0] b, output int n_low);
    byte_in    = b;
    byte_valid = 1'b1;
    n_low      = 0;
    @(negedge clk);
    while (!rdy() && n_low < 40) begin
      n_low++;
      @(negedge clk);
    end
    if (n_low >= 40) check("byte_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int cycles);
    byte_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    int n;
    send(b0, n); send(b1, n); send(b2, n);
    send(b3, n); send(b4, n); send(b5, n);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_byte_ready"}, ready_a, 0);
    check({tag, "_word_out"},   wo_a,    0);
    check({tag, "_word_idx"},   idx_a,   0);
    check({tag, "_word_valid"}, wv_a,    0);
    check({tag, "_crc_err"},    ce_a,    0);
    check({tag, "_frame_done"}, fd_a,    0);
    check({tag, "_frame_err"},  fe_a,    0);
    check({tag, "_err_count"},  ec_a,    0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    en_a = 1'b1; en_b = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_a_zero("reset");
    check("reset_B_byte_ready", ready_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    en_b = 1'b0;
    idle(2);

    // Clean SHT40 frame on A.
    q_a.push_back(mk(3'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0));
    q_a.push_back(mk(3'd1, 16'h6666, 1'b0, 1'b1, 1'b0));
    pulse_start();
    send_frame(8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93);
    idle(3);
    check("clean_frame_err", fe_a, 0);
    check("clean_err_count", ec_a, 0);

    // Bad CRC on the last word.
    q_a.push_back(mk(3'd0, 16'h0000, 1'b0, 1'b0, 1'b0));
    q_a.push_back(mk(3'd1, 16'h0000, 1'b1, 1'b1, 1'b1));
    pulse_start();
    send_frame(8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00);
    idle(3);
    exp_err_a = 1;
    check("lastbad_frame_err", fe_a, 1);
    check("lastbad_err_count", ec_a, exp_err_a);

    // Bad CRC on word 0 aborts the frame on A: the rest is refused.
    q_a.push_back(mk(3'd0, 16'hBEEF, 1'b1, 1'b1, 1'b1));
    pulse_start();
    send(8'hBE, lows); send(8'hEF, lows); send(8'h00, lows);
    byte_in = 8'h66;
    highs = 0;
    repeat (12) begin
      @(negedge clk);
      if (ready_a) highs++;
    end
    check("abort_refuses_bytes", highs, 0);
    idle(1);
    exp_err_a = 2;
    check("abort_err_count", ec_a, exp_err_a);
    check("abort_frame_err", fe_a, 1);

    // Same bad first word on B continues with the second word.
    en_a = 1'b0; en_b = 1'b1; sel = 1'b1;
    q_b.push_back(mk(3'd0, 16'hBEEF, 1'b1, 1'b0, 1'b1));
    q_b.push_back(mk(3'd1, 16'h6666, 1'b0, 1'b1, 1'b1));
    pulse_start();
    send_frame(8'hBE, 8'hEF, 8'h00, 8'h66, 8'h66, 8'h93);
    idle(3);
    check("noabort_frame_err", fe_b, 1);
    check("noabort_err_count", ec_b, 1);
    en_a = 1'b1; en_b = 1'b0; sel = 1'b0;

    // frame_start three cycles into SHIFT drops the partial word silently.
    pulse_start();
    send(8'hBE, lows);
    @(posedge clk); #1;
    @(posedge clk); #1;
    q_a.push_back(mk(3'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0));
    q_a.push_back(mk(3'd1, 16'h6666, 1'b0, 1'b1, 1'b0));
    pulse_start();
    byte_valid = 1'b0;
    send_frame(8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93);
    idle(3);
    check("restart_frame_err", fe_a, 0);
    check("restart_err_count", ec_a, exp_err_a);

    // byte_valid held high: ready drops for exactly 8 cycles after a data byte.
    q_a.push_back(mk(3'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0));
    q_a.push_back(mk(3'd1, 16'h6666, 1'b0, 1'b1, 1'b0));
    pulse_start();
    send(8'hBE, lows); check("stream_gap_first", lows, 0);
    send(8'hEF, lows); check("stream_gap_data1", lows, 8);
    send(8'h92, lows); check("stream_gap_crc0",  lows, 8);
    send(8'h66, lows); check("stream_gap_report", lows, 1);
    send(8'h66, lows); check("stream_gap_data3", lows, 8);
    send(8'h93, lows); check("stream_gap_crc1",  lows, 8);
    idle(3);
    check("stream_queue_drained", q_a.size(), 0);

    // Reset in the middle of SHIFT.
    pulse_start();
    send(8'hBE, lows);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_a_zero("midshift_rst");
    exp_err_a = 0;
    byte_valid = 1'b1;
    highs = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_a) highs++;
    end
    check("post_rst_idle", highs, 0);
    idle(1);

    // 257 bad words: err_count climbs to 8'hFF and stays there.
    for (int i = 0; i < 257; i++) begin
      q_a.push_back(mk(3'd0, 16'h0000, 1'b1, 1'b1, 1'b1));
      pulse_start();
      send(8'h00, lows); send(8'h00, lows); send(8'h00, lows);
      exp_err_a = (exp_err_a == 255) ? 255 : exp_err_a + 1;
      if (i >= 252) check("sat_err_count", ec_a, exp_err_a);
      byte_valid = 1'b0;
    end
    idle(3);
    check("sat_final", ec_a, 8'hFF);

    check("A_queue_empty", q_a.size(), 0);
    check("B_queue_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
